// File: rtl/mult_seq_radix_pipe.sv
`default_nettype none
// ============================================================================
// Module   : mult_seq_radix_pipe
// Purpose  : Sequential radix-2^DIGIT multiplier. It forms one DIGITxDIGIT
//            partial product per cycle and uses valid/ready on both sides.
// Revision : 1.0 - initial release
// ============================================================================
module mult_seq_radix_pipe #(
    parameter int WIDTH     = 8,
    parameter int DIGIT     = 4,
    parameter int SIGNED_EN = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 is_signed,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   p,
    output logic                 busy
);

    localparam int c_ndig = WIDTH / DIGIT;
    localparam int c_cw   = (c_ndig > 1) ? $clog2(c_ndig) : 1;
    localparam int c_aw   = 2 * WIDTH + 1;
    localparam logic [c_cw-1:0] c_last = c_cw'(c_ndig - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_CALC = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]           r_state;
    logic [1:0]           w_state_next;
    logic [WIDTH:0]       r_a_mag;
    logic [WIDTH:0]       r_b_mag;
    logic                 r_neg;
    logic [c_aw-1:0]      r_acc;
    logic [c_cw-1:0]      r_i;
    logic [c_cw-1:0]      r_j;
    logic [2*WIDTH-1:0]   r_p;

    logic                 w_sgn;
    logic [WIDTH:0]       w_a_mag;
    logic [WIDTH:0]       w_b_mag;
    logic [31:0]          w_a_sh;
    logic [31:0]          w_b_sh;
    logic [31:0]          w_shamt;
    logic [DIGIT-1:0]     w_digit_a;
    logic [DIGIT-1:0]     w_digit_b;
    logic [2*DIGIT-1:0]   w_pp;
    logic [c_aw-1:0]      w_shift_pp;
    logic [c_aw-1:0]      w_acc_next;
    logic [2*WIDTH-1:0]   w_prod;
    logic [2*WIDTH-1:0]   w_p_final;
    logic                 w_last_pp;

    // Magnitudes carry one extra bit so -2^(WIDTH-1) keeps its positive form.
    assign w_sgn   = (SIGNED_EN != 0) && is_signed;
    assign w_a_mag = (w_sgn && a[WIDTH-1]) ? -{1'b1, a} : {1'b0, a};
    assign w_b_mag = (w_sgn && b[WIDTH-1]) ? -{1'b1, b} : {1'b0, b};

    assign w_a_sh     = DIGIT * 32'(r_i);
    assign w_b_sh     = DIGIT * 32'(r_j);
    assign w_shamt    = DIGIT * (32'(r_i) + 32'(r_j));
    assign w_digit_a  = DIGIT'(r_a_mag >> w_a_sh);
    assign w_digit_b  = DIGIT'(r_b_mag >> w_b_sh);
    assign w_pp       = (2*DIGIT)'(w_digit_a) * (2*DIGIT)'(w_digit_b);
    assign w_shift_pp = c_aw'(w_pp) << w_shamt;
    assign w_acc_next = r_acc + w_shift_pp;
    assign w_prod     = w_acc_next[2*WIDTH-1:0];
    assign w_p_final  = r_neg ? -w_prod : w_prod;
    assign w_last_pp  = (r_i == c_last) && (r_j == c_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE:  if (in_valid)  w_state_next = c_CALC;
            c_CALC:  if (w_last_pp) w_state_next = c_DONE;
            c_DONE:  if (out_ready) w_state_next = c_IDLE;
            default: w_state_next = c_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_mag <= '0;
            r_b_mag <= '0;
            r_neg   <= 1'b0;
            r_acc   <= '0;
            r_i     <= '0;
            r_j     <= '0;
            r_p     <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (in_valid) begin
                        r_a_mag <= w_a_mag;
                        r_b_mag <= w_b_mag;
                        r_neg   <= w_sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
                        r_acc   <= '0;
                        r_i     <= '0;
                        r_j     <= '0;
                    end
                end
                c_CALC: begin
                    r_acc <= w_acc_next;
                    if (r_j == c_last) begin
                        r_j <= '0;
                        r_i <= r_i + c_cw'(1);
                    end else begin
                        r_j <= r_j + c_cw'(1);
                    end
                    // The final product is registered on the same edge that enters DONE.
                    if (w_last_pp) begin
                        r_p <= w_p_final;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == c_IDLE);
    assign busy      = (r_state == c_CALC);
    assign out_valid = (r_state == c_DONE);
    assign p         = r_p;

endmodule
`default_nettype wire

// File: tb/tb_mult_seq_radix_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult_seq_radix_pipe
// Purpose  : Scoreboard bench for mult_seq_radix_pipe with an arithmetic
//            reference model, backpressure, a mid-calculation reset and
//            continuous-valid traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mult_seq_radix_pipe;

    localparam int W   = 8;
    localparam int D   = 4;
    localparam int SE  = 1;
    localparam int N   = W / D;
    localparam int LAT = N * N + 1;
    localparam int GAP = N * N + 2;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           is_signed;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] p;
    logic           busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int mode   = 0;   // 0: out_ready high, 1: random, 2: held low

    logic [2*W-1:0] exp_q[$];
    int             acc_q[$];

    mult_seq_radix_pipe #(.WIDTH(W), .DIGIT(D), .SIGNED_EN(SE)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .is_signed (is_signed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .p         (p),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Plain integer product of the operands, truncated to 2*W bits.
    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y,
                                               input logic s);
        longint xv = longint'(x);
        longint yv = longint'(y);
        if (s && (SE != 0)) begin
            if (x[W-1]) xv = xv - (longint'(1) << W);
            if (y[W-1]) yv = yv - (longint'(1) << W);
        end
        return (2*W)'(xv * yv);
    endfunction

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Presents one operand pair and returns the cycle it was accepted in.
    task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic ts,
                         output int acc_cyc);
        bit ok = 1'b0;
        acc_cyc = -1;
        in_valid = 1'b1; a = ta; b = tb; is_signed = ts;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(ref_mul(ta, tb, ts));
                acc_q.push_back(cyc);
                acc_cyc = cyc;
                ok = 1'b1;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("accept_within_bound", longint'(ok), 1);
    endtask

    task automatic drain(input int lim);
        bit done = 1'b0;
        for (int n = 0; n < lim && !done; n++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && in_ready) done = 1'b1;
        end
        check("drain_within_bound", longint'(done), 1);
        @(posedge clk); #1;
    endtask

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: latency, stability under backpressure, scoreboard compare.
    initial begin
        bit       prev_v    = 1'b0;
        bit       prev_cons = 1'b0;
        logic [2*W-1:0] held_p = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_v = 1'b0; prev_cons = 1'b0;
                continue;
            end
            if (prev_cons) begin
                check("out_valid_drops_after_accept", longint'(out_valid), 0);
                check("in_ready_after_accept", longint'(in_ready), 1);
            end
            prev_cons = 1'b0;
            if (out_valid) begin
                if (!prev_v) begin
                    if (acc_q.size() == 0) begin
                        check("unexpected_output", 1, 0);
                    end else begin
                        check("latency", longint'(cyc - acc_q[0]), LAT);
                    end
                    held_p = p;
                end else begin
                    check("p_stable_backpressure", longint'(p), longint'(held_p));
                end
                check("in_ready_low_in_done", longint'(in_ready), 0);
                if (out_ready) begin
                    if (exp_q.size() != 0) begin
                        check("product", longint'(p), longint'(exp_q.pop_front()));
                        void'(acc_q.pop_front());
                    end
                    prev_cons = 1'b1;
                end
            end
            prev_v = out_valid && !out_ready;
        end
    end

    initial begin
        int ac;
        int last_ac;
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; is_signed = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_in_ready", longint'(in_ready), 1);
        check("reset_out_valid", longint'(out_valid), 0);
        check("reset_p", longint'(p), 0);
        check("reset_busy", longint'(busy), 0);
        @(posedge clk); #1;

        // Directed corner operands.
        issue(8'hFF, 8'hFF, 1'b0, ac);
        @(negedge clk);
        check("busy_in_calc", longint'(busy), 1);
        @(posedge clk); #1;
        issue(8'h00, 8'h37, 1'b0, ac);
        issue(8'h80, 8'h80, 1'b1, ac);
        issue(8'hFF, 8'h05, 1'b1, ac);
        issue(8'h7F, 8'h81, 1'b1, ac);
        issue(8'h80, 8'h7F, 1'b1, ac);
        issue(8'h80, 8'h80, 1'b0, ac);
        drain(100);

        // Backpressure: hold the product for 10 cycles.
        mode = 2;
        @(posedge clk); #1;
        issue(8'h9C, 8'h35, 1'b1, ac);
        begin
            bit seen = 1'b0;
            for (int n = 0; n < 100 && !seen; n++) begin
                @(negedge clk);
                if (out_valid) seen = 1'b1;
            end
            check("out_valid_seen", longint'(seen), 1);
        end
        repeat (10) @(negedge clk);
        @(posedge clk); #1;
        mode = 0;
        drain(100);

        // Reset during the second CALC cycle aborts the operation.
        issue(8'h05, 8'h09, 1'b0, ac);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        acc_q.delete();
        @(negedge clk);
        check("abort_in_ready", longint'(in_ready), 1);
        check("abort_out_valid", longint'(out_valid), 0);
        check("abort_p", longint'(p), 0);
        check("abort_busy", longint'(busy), 0);
        @(posedge clk); #1;
        issue(8'd3, 8'd7, 1'b0, ac);
        drain(100);

        // Continuous in_valid: one accept per GAP cycles.
        last_ac = -1;
        for (int k = 0; k < 20; k++) begin
            issue(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), ac);
            if (last_ac >= 0) check("accept_spacing", longint'(ac - last_ac), GAP);
            last_ac = ac;
        end
        drain(100);

        // Random traffic with random backpressure.
        mode = 1;
        for (int k = 0; k < 1500; k++) begin
            issue(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), ac);
        end
        mode = 0;
        drain(200);

        check("scoreboard_empty", longint'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
